// File: rtl/lcd_frame_streamer_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : lcd_frame_streamer_if
// Purpose  : Bundles the streamer's control handshake, pixel-source bus and
//            SPI panel pins. The master side is the streamer itself; the
//            slave side is the frame source / panel environment.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
interface lcd_frame_streamer_if;
  logic        start;
  logic        busy;
  logic        frame_done;
  logic [7:0]  row_addr;
  logic [7:0]  col_addr;
  logic [15:0] pix_data;
  logic        lcd_clk_out;
  logic        lcd_data_out;
  logic        lcd_dc_out;
  logic        lcd_cs_n_out;

  modport master (
    input  start, pix_data,
    output busy, frame_done, row_addr, col_addr,
           lcd_clk_out, lcd_data_out, lcd_dc_out, lcd_cs_n_out
  );

  modport slave (
    output start, pix_data,
    input  busy, frame_done, row_addr, col_addr,
           lcd_clk_out, lcd_data_out, lcd_dc_out, lcd_cs_n_out
  );
endinterface
`default_nettype wire

// File: rtl/lcd_frame_streamer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : lcd_frame_streamer
// Purpose  : Streams one full RGB565 frame to an SPI LCD panel: column and
//            row window commands, memory-write command, then every pixel in
//            row-major order, high byte first. SPI mode 0, MSB first.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module lcd_frame_streamer #(
  parameter int LCD_W   = 132,
  parameter int LCD_H   = 162,
  parameter int CLK_DIV = 4
) (
  input  wire logic                 clk,
  input  wire logic                 rst_n,
  lcd_frame_streamer_if.master      bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CASET = 3'd1,
    S_RASET = 3'd2,
    S_RAMWR = 3'd3,
    S_PIXEL = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [7:0]  c_COL_LAST = 8'(LCD_W - 1);
  localparam logic [7:0]  c_ROW_LAST = 8'(LCD_H - 1);
  localparam logic [15:0] c_DIV_LAST = 16'(CLK_DIV - 1);

  // Header byte table: index 0..10 covers CASET (0-4), RASET (5-9), RAMWR (10).
  // Bit 8 is the D/C level for that byte.
  function automatic logic [8:0] hdr_byte(input logic [3:0] idx);
    case (idx)
      4'd0:    hdr_byte = {1'b0, 8'h2A};
      4'd4:    hdr_byte = {1'b1, c_COL_LAST};
      4'd5:    hdr_byte = {1'b0, 8'h2B};
      4'd9:    hdr_byte = {1'b1, c_ROW_LAST};
      4'd10:   hdr_byte = {1'b0, 8'h2C};
      default: hdr_byte = {1'b1, 8'h00};
    endcase
  endfunction

  state_t      r_state;
  state_t      w_next;

  logic [15:0] r_div;
  logic        r_sclk;
  logic [2:0]  r_bit;
  logic [7:0]  r_shift;
  logic        r_dc;
  logic        r_cs_n;
  logic        r_busy;
  logic        r_done;
  logic [3:0]  r_idx;
  logic [7:0]  r_row;
  logic [7:0]  r_col;
  logic [15:0] r_hold;
  logic        r_lo;
  logic        r_last;
  logic        r_lat0;
  logic        r_lat1;

  logic        w_active;
  logic        w_accept;
  logic        w_bit_end;
  logic        w_byte_end;
  logic        w_frame_end;
  logic [8:0]  w_hdr_next;
  logic [8:0]  w_hdr_first;

  assign w_active    = (r_state == S_CASET) || (r_state == S_RASET) ||
                       (r_state == S_RAMWR) || (r_state == S_PIXEL);
  assign w_accept    = (r_state == S_IDLE) && bus.start;
  assign w_bit_end   = w_active && r_sclk && (r_div == c_DIV_LAST);
  assign w_byte_end  = w_bit_end && (r_bit == 3'd7);
  assign w_frame_end = w_byte_end && (r_state == S_PIXEL) && r_lo && r_last;
  assign w_hdr_next  = hdr_byte(r_idx + 4'd1);
  assign w_hdr_first = hdr_byte(4'd0);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode: phases advance only on byte boundaries.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_CASET;
      S_CASET: if (w_byte_end && (r_idx == 4'd4)) w_next = S_RASET;
      S_RASET: if (w_byte_end && (r_idx == 4'd9)) w_next = S_RAMWR;
      S_RAMWR: if (w_byte_end) w_next = S_PIXEL;
      S_PIXEL: if (w_frame_end) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // SPI shifter, byte sequencing, pixel addressing and frame status flags.
  // The next pixel address is issued at the start of each low byte; the
  // source answers one cycle later, so the holding register samples two
  // cycles after the address change, well before the low byte completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div   <= '0;
      r_sclk  <= 1'b0;
      r_bit   <= '0;
      r_shift <= '0;
      r_dc    <= 1'b0;
      r_cs_n  <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_idx   <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_hold  <= '0;
      r_lo    <= 1'b0;
      r_last  <= 1'b0;
      r_lat0  <= 1'b0;
      r_lat1  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_lat0 <= 1'b0;
      r_lat1 <= r_lat0;
      if (r_lat1) r_hold <= bus.pix_data;

      if (w_accept) begin
        r_cs_n  <= 1'b0;
        r_busy  <= 1'b1;
        r_sclk  <= 1'b0;
        r_div   <= '0;
        r_bit   <= '0;
        r_shift <= w_hdr_first[7:0];
        r_dc    <= w_hdr_first[8];
        r_idx   <= '0;
        r_row   <= '0;
        r_col   <= '0;
        r_lo    <= 1'b0;
        r_last  <= 1'b0;
        r_lat0  <= 1'b1;
      end else if (w_active) begin
        if (r_div != c_DIV_LAST) begin
          r_div <= r_div + 16'd1;
        end else begin
          r_div  <= '0;
          r_sclk <= ~r_sclk;
          if (r_sclk) begin
            if (r_bit != 3'd7) begin
              r_bit   <= r_bit + 3'd1;
              r_shift <= {r_shift[6:0], 1'b0};
            end else begin
              r_bit <= '0;
              if (w_frame_end) begin
                r_cs_n  <= 1'b1;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_shift <= '0;
                r_dc    <= 1'b0;
              end else if ((r_state == S_PIXEL) && !r_lo) begin
                r_shift <= r_hold[7:0];
                r_dc    <= 1'b1;
                r_lo    <= 1'b1;
                if ((r_row == c_ROW_LAST) && (r_col == c_COL_LAST)) begin
                  r_last <= 1'b1;
                end else begin
                  r_lat0 <= 1'b1;
                  if (r_col == c_COL_LAST) begin
                    r_col <= '0;
                    r_row <= r_row + 8'd1;
                  end else begin
                    r_col <= r_col + 8'd1;
                  end
                end
              end else if ((r_state == S_RAMWR) || (r_state == S_PIXEL)) begin
                r_shift <= r_hold[15:8];
                r_dc    <= 1'b1;
                r_lo    <= 1'b0;
              end else begin
                r_idx   <= r_idx + 4'd1;
                r_shift <= w_hdr_next[7:0];
                r_dc    <= w_hdr_next[8];
              end
            end
          end
        end
      end
    end
  end

  assign bus.row_addr     = r_row;
  assign bus.col_addr     = r_col;
  assign bus.lcd_clk_out  = r_sclk;
  assign bus.lcd_data_out = r_shift[7];
  assign bus.lcd_dc_out   = r_dc;
  assign bus.lcd_cs_n_out = r_cs_n;
  assign bus.busy         = r_busy;
  assign bus.frame_done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_lcd_frame_streamer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_lcd_frame_streamer
// Purpose  : Self-checking bench. DUT A uses default geometry (header and
//            first pixels, then reset); DUT B uses a 4x2 panel with
//            CLK_DIV=1 for full frames, ignored starts and mid-frame abort.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_lcd_frame_streamer;

  localparam int AW = 132, AH = 162, AD = 4;
  localparam int BW = 4,   BH = 2,   BD = 1;

  logic clk = 1'b0;
  logic rst_n_a;
  logic rst_n_b;

  always #5 clk = ~clk;

  lcd_frame_streamer_if ifa();
  lcd_frame_streamer_if ifb();

  lcd_frame_streamer #(.LCD_W(AW), .LCD_H(AH), .CLK_DIV(AD)) u_a (
    .clk (clk),
    .rst_n (rst_n_a),
    .bus (ifa.master)
  );

  lcd_frame_streamer #(.LCD_W(BW), .LCD_H(BH), .CLK_DIV(BD)) u_b (
    .clk (clk),
    .rst_n (rst_n_b),
    .bus (ifb.master)
  );

  // Pixel sources: data equals {row, col}, answering one cycle after the address.
  always @(posedge clk) begin
    ifa.pix_data <= {ifa.row_addr, ifa.col_addr};
    ifb.pix_data <= {ifb.row_addr, ifb.col_addr};
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Byte k of a frame as {dc, value}, straight from the frame layout rules.
  function automatic logic [8:0] exp_byte(input int w, input int h, input int k);
    int p;
    case (k)
      0:                return 9'h02A;
      5:                return 9'h02B;
      10:               return 9'h02C;
      1, 2, 3, 6, 7, 8: return 9'h100;
      4:                return {1'b1, 8'(w - 1)};
      9:                return {1'b1, 8'(h - 1)};
      default: begin
        p = (k - 11) / 2;
        if (((k - 11) % 2) == 0) return {1'b1, 8'(p / w)};
        else                     return {1'b1, 8'(p % w)};
      end
    endcase
  endfunction

  // Frame-level model: active flag, cycle index within frame, DONE cycle.
  bit m_act  [2] = '{1'b0, 1'b0};
  bit m_done [2] = '{1'b0, 1'b0};
  int m_t    [2] = '{0, 0};
  int m_total[2] = '{(11 + 2*AW*AH)*16*AD, (11 + 2*BW*BH)*16*BD};

  always @(posedge clk) begin
    logic [1:0] rs;
    logic [1:0] st;
    rs = {rst_n_b, rst_n_a};
    st = {ifb.start, ifa.start};
    for (int k = 0; k < 2; k++) begin
      if (!rs[k]) begin
        m_act[k]  = 1'b0;
        m_done[k] = 1'b0;
      end else if (m_act[k]) begin
        if (m_t[k] == m_total[k] - 1) begin
          m_act[k]  = 1'b0;
          m_done[k] = 1'b1;
        end else begin
          m_t[k]++;
        end
      end else if (m_done[k]) begin
        m_done[k] = 1'b0;
      end else if (st[k]) begin
        m_act[k] = 1'b1;
        m_t[k]   = 0;
      end
    end
  end

  // Per-cycle compare of {row, col, cs_n, busy, frame_done, sclk, data, dc}.
  always @(negedge clk) begin
    logic [21:0] act_v;
    logic [21:0] exp_v;
    logic [21:0] msk;
    logic [8:0]  eb;
    logic        rs;
    int w, h, d, kk, rem;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        act_v = {ifa.row_addr, ifa.col_addr, ifa.lcd_cs_n_out, ifa.busy, ifa.frame_done,
                 ifa.lcd_clk_out, ifa.lcd_data_out, ifa.lcd_dc_out};
        rs = rst_n_a; w = AW; h = AH; d = AD;
      end else begin
        act_v = {ifb.row_addr, ifb.col_addr, ifb.lcd_cs_n_out, ifb.busy, ifb.frame_done,
                 ifb.lcd_clk_out, ifb.lcd_data_out, ifb.lcd_dc_out};
        rs = rst_n_b; w = BW; h = BH; d = BD;
      end
      if (!rs) begin
        exp_v = {16'h0000, 6'b100000};
        msk   = '1;
      end else if (m_act[k]) begin
        kk  = m_t[k] / (16*d);
        rem = m_t[k] % (16*d);
        eb  = exp_byte(w, h, kk);
        exp_v = {16'h0000, 1'b0, 1'b1, 1'b0, ((rem % (2*d)) >= d), eb[7 - rem/(2*d)], eb[8]};
        msk   = 22'h3F;
      end else if (m_done[k]) begin
        exp_v = {16'h0000, 6'b101000};
        msk   = 22'h3C;
      end else begin
        exp_v = {16'h0000, 6'b100000};
        msk   = 22'h3C;
      end
      check((k == 0) ? "A_pins" : "B_pins", 32'(act_v & msk), 32'(exp_v & msk));
    end
  end

  // SPI decoders: sample MOSI on each rising SCLK, collect {dc, byte}.
  logic [8:0] qa[$];
  logic [8:0] qb[$];
  logic [7:0] a_sh, b_sh;
  int  a_nb = 0, b_nb = 0;
  logic a_prev = 1'b0, b_prev = 1'b0;
  int  b_len = 0, b_fd = 0;

  always @(negedge clk) begin
    if (ifa.lcd_cs_n_out) a_nb = 0;
    else if (ifa.lcd_clk_out && !a_prev) begin
      a_sh = {a_sh[6:0], ifa.lcd_data_out};
      a_nb++;
      if (a_nb == 8) begin qa.push_back({ifa.lcd_dc_out, a_sh}); a_nb = 0; end
    end
    a_prev = ifa.lcd_clk_out;

    if (ifb.lcd_cs_n_out) b_nb = 0;
    else begin
      b_len++;
      if (ifb.lcd_clk_out && !b_prev) begin
        b_sh = {b_sh[6:0], ifb.lcd_data_out};
        b_nb++;
        if (b_nb == 8) begin qb.push_back({ifb.lcd_dc_out, b_sh}); b_nb = 0; end
      end
    end
    if (ifb.frame_done) b_fd++;
    b_prev = ifb.lcd_clk_out;
  end

  task automatic wait_done_b(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (ifb.frame_done) begin seen = 1'b1; break; end
    end
  endtask

  task automatic pulse_b;
    ifb.start = 1'b1;
    @(posedge clk); #1;
    ifb.start = 1'b0;
  endtask

  logic [8:0] hdr_lit [11] = '{9'h02A, 9'h100, 9'h100, 9'h100, 9'h183,
                               9'h02B, 9'h100, 9'h100, 9'h100, 9'h1A1, 9'h02C};

  initial begin
    bit seen;
    rst_n_a = 1'b0; rst_n_b = 1'b0;
    ifa.start = 1'b0; ifb.start = 1'b0;
    repeat (3) @(posedge clk); #1;
    rst_n_a = 1'b1; rst_n_b = 1'b1;
    repeat (4) @(posedge clk); #1;

    // DUT A: header and first two pixels at default geometry, then reset.
    ifa.start = 1'b1;
    @(posedge clk); #1;
    ifa.start = 1'b0;
    repeat (15*64 + 10) @(posedge clk); #1;
    rst_n_a = 1'b0;
    repeat (2) @(posedge clk); #1;
    rst_n_a = 1'b1;
    check("A_bytes_seen", 32'(qa.size() >= 15), 32'd1);
    if (qa.size() >= 15) begin
      for (int i = 0; i < 11; i++) check("A_header_byte", 32'(qa[i]), 32'(hdr_lit[i]));
      check("A_pix00_hi", 32'(qa[11]), 32'h100);
      check("A_pix00_lo", 32'(qa[12]), 32'h100);
      check("A_pix01_hi", 32'(qa[13]), 32'h100);
      check("A_pix01_lo", 32'(qa[14]), 32'h101);
    end

    // DUT B frame 1: re-pulse start inside byte 5 and in DONE; both ignored.
    qb.delete(); b_len = 0; b_fd = 0;
    pulse_b();
    repeat (80) @(posedge clk); #1;
    pulse_b();
    wait_done_b(seen);
    check("B1_done_seen", 32'(seen), 32'd1);
    ifb.start = 1'b1;
    @(posedge clk); #1;
    ifb.start = 1'b0;
    repeat (20) @(posedge clk); #1;
    check("B1_byte_count", 32'(qb.size()), 32'd27);
    check("B1_cs_low_cycles", 32'(b_len), 32'd432);
    check("B1_done_pulses", 32'(b_fd), 32'd1);
    if (qb.size() == 27) begin
      check("B1_caset_cmd", 32'(qb[0]), 32'h02A);
      check("B1_col_end", 32'(qb[4]), 32'h103);
      check("B1_row_end", 32'(qb[9]), 32'h101);
      check("B1_ramwr_cmd", 32'(qb[10]), 32'h02C);
      check("B1_last_hi", 32'(qb[25]), 32'h101);
      check("B1_last_lo", 32'(qb[26]), 32'h103);
      for (int i = 0; i < 27; i++) check("B1_stream", 32'(qb[i]), 32'(exp_byte(BW, BH, i)));
    end

    // DUT B frame 2: abort by reset during pixel (1,2); no frame_done.
    qb.delete(); b_len = 0; b_fd = 0;
    pulse_b();
    repeat (372) @(posedge clk); #1;
    rst_n_b = 1'b0;
    repeat (3) @(posedge clk); #1;
    rst_n_b = 1'b1;
    repeat (5) @(posedge clk); #1;
    check("B2_no_done_on_abort", 32'(b_fd), 32'd0);

    // DUT B frame 3: fresh frame restarts with the column command.
    qb.delete(); b_len = 0; b_fd = 0;
    pulse_b();
    wait_done_b(seen);
    check("B3_done_seen", 32'(seen), 32'd1);
    repeat (5) @(posedge clk); #1;
    check("B3_byte_count", 32'(qb.size()), 32'd27);
    check("B3_cs_low_cycles", 32'(b_len), 32'd432);
    check("B3_done_pulses", 32'(b_fd), 32'd1);
    if (qb.size() > 0) check("B3_first_byte", 32'(qb[0]), 32'h02A);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
